scroll_latch_writer: RTL and testbench

Synthesizable initiator for the tile-generator scroll-latch write protocol. It holds one 9-bit horizontal scroll offset per layer and, once per frame on the rising edge of VBLANK, replays them as byte-wide address/data/LATCH strobe writes into the CUS42/CUS43 scroll registers. It replaces hand-timed bench stimulus with a cycle-exact sequencer on the CLK_6M domain. An optional per-frame auto-increment supports scroll sweeps.

---
 rtl/scroll_latch_writer.sv | 192 +++++++++++++++++++
 tb/tb_scroll_latch_writer.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scroll_latch_writer.sv
// scroll_latch_writer: replays per-layer 9-bit scroll offsets into the
// CUS42/CUS43 scroll latches once per frame, on the rising edge of VBLANK.
// Each offset goes out as two byte writes (low, then high), each framed as
// SETUP -> STROBE (LATCH high) -> HOLD, so A/D never move while LATCH is high.
module scroll_latch_writer #(
  parameter int LAYERS        = 2,  // 1..4
  parameter int SETUP_CYCLES  = 1,  // >= 1
  parameter int STROBE_CYCLES = 1,  // >= 1
  parameter int STEP          = 1   // per-frame auto-increment, modulo 512
) (
  input  logic       CLK_6M,
  input  logic       RST_N,
  input  logic       VBLANK,
  input  logic       EN,
  input  logic       AUTO_INC,
  input  logic       HOST_WE,
  input  logic [1:0] HOST_SEL,
  input  logic [8:0] HOST_OFS,
  output logic [2:0] A,
  output logic [7:0] D,
  output logic       LATCH,
  output logic       BUSY,
  output logic       DONE,
  output logic       OVERRUN
);

  localparam int CNT_MAX = (SETUP_CYCLES > STROBE_CYCLES) ? SETUP_CYCLES : STROBE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] STROBE_LAST = CNT_W'(STROBE_CYCLES - 1);
  localparam logic [2:0]       LAST_WR     = 3'(2 * LAYERS - 1);
  localparam logic [8:0]       STEP9       = 9'(STEP % 512);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_t;

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [2:0]       wr_reg, wr_next;      // write index; equals the A value of that write
  logic             dirty_reg, dirty_next;
  logic             overrun_next;
  logic [2:0]       a_next;
  logic [7:0]       d_next;
  logic             vb_s1_reg, vb_s2_reg, trig_reg;
  logic             host_valid;

  // Arrays are sized for the maximum of four layers; layers >= LAYERS stay zero.
  logic [8:0] ofs_reg  [4];
  logic [8:0] ofs_next [4];
  logic [8:0] snap_reg [4];

  // Low byte carries bits [7:0]; high byte carries only bit 8 in its LSB.
  function automatic logic [7:0] byte_of(input logic hi, input logic [8:0] v);
    return hi ? {7'b0, v[8]} : v[7:0];
  endfunction

  assign host_valid = HOST_WE && (int'(HOST_SEL) < LAYERS);

  // Two-flop VBLANK synchronizer plus a registered rising-edge trigger.
  always_ff @(posedge CLK_6M or negedge RST_N) begin
    if (!RST_N) begin
      vb_s1_reg <= 1'b0;
      vb_s2_reg <= 1'b0;
      trig_reg  <= 1'b0;
    end else begin
      vb_s1_reg <= VBLANK;
      vb_s2_reg <= vb_s1_reg;
      trig_reg  <= vb_s1_reg & ~vb_s2_reg;
    end
  end

  // Shadow update: a host write to a layer beats the LOAD auto-increment.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      ofs_next[i] = ofs_reg[i];
      if (i < LAYERS) begin
        if (host_valid && (HOST_SEL == 2'(i))) begin
          ofs_next[i] = HOST_OFS;
        end else if ((state_reg == S_LOAD) && AUTO_INC) begin
          ofs_next[i] = ofs_reg[i] + STEP9;
        end
      end
    end
  end

  // Next-state logic; A/D only change when entering SETUP or DONE.
  always_comb begin
    state_next   = state_reg;
    cnt_next     = cnt_reg;
    wr_next      = wr_reg;
    a_next       = A;
    d_next       = D;
    dirty_next   = dirty_reg | host_valid;
    overrun_next = OVERRUN | (trig_reg && (state_reg != S_IDLE));

    case (state_reg)
      S_IDLE: begin
        if (trig_reg && (EN || dirty_reg || AUTO_INC)) begin
          state_next = S_LOAD;
        end
      end
      S_LOAD: begin
        // Snapshot is taken now; a host write landing in this cycle stays pending.
        dirty_next = host_valid;
        state_next = S_SETUP;
        cnt_next   = '0;
        wr_next    = 3'd0;
        a_next     = 3'd0;
        d_next     = byte_of(1'b0, ofs_next[0]);
      end
      S_SETUP: begin
        if (cnt_reg == SETUP_LAST) begin
          state_next = S_STROBE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_STROBE: begin
        if (cnt_reg == STROBE_LAST) begin
          state_next = S_HOLD;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      S_HOLD: begin
        if (wr_reg == LAST_WR) begin
          state_next = S_DONE;
          a_next     = 3'd0;
          d_next     = 8'd0;
        end else begin
          state_next = S_SETUP;
          cnt_next   = '0;
          wr_next    = wr_reg + 3'd1;
          a_next     = wr_next;
          d_next     = byte_of(wr_next[0], snap_reg[wr_next[2:1]]);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // State, shadows, snapshot and registered outputs.
  always_ff @(posedge CLK_6M or negedge RST_N) begin
    if (!RST_N) begin
      state_reg <= S_IDLE;
      cnt_reg   <= '0;
      wr_reg    <= 3'd0;
      dirty_reg <= 1'b0;
      A         <= 3'd0;
      D         <= 8'd0;
      LATCH     <= 1'b0;
      BUSY      <= 1'b0;
      DONE      <= 1'b0;
      OVERRUN   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        ofs_reg[i]  <= 9'd0;
        snap_reg[i] <= 9'd0;
      end
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      wr_reg    <= wr_next;
      dirty_reg <= dirty_next;
      A         <= a_next;
      D         <= d_next;
      LATCH     <= (state_next == S_STROBE);
      BUSY      <= (state_next != S_IDLE);
      DONE      <= (state_next == S_DONE);
      OVERRUN   <= overrun_next;
      for (int i = 0; i < 4; i++) begin
        ofs_reg[i] <= ofs_next[i];
        if (state_reg == S_LOAD) begin
          snap_reg[i] <= ofs_next[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_scroll_latch_writer.sv
// Testbench for scroll_latch_writer: directed frames from the test plan plus a
// randomized run, all checked cycle by cycle against a frame-level model.
module tb_scroll_latch_writer;

  localparam int LAYERS        = 2;
  localparam int SETUP_CYCLES  = 1;
  localparam int STROBE_CYCLES = 1;
  localparam int STEP          = 1;
  localparam int WR_LEN        = SETUP_CYCLES + STROBE_CYCLES + 1;
  localparam int SEQ_LEN       = 2 + 2 * LAYERS * WR_LEN;

  logic       CLK_6M = 1'b0;
  logic       RST_N = 1'b0;
  logic       VBLANK = 1'b0;
  logic       EN = 1'b0;
  logic       AUTO_INC = 1'b0;
  logic       HOST_WE = 1'b0;
  logic [1:0] HOST_SEL = 2'd0;
  logic [8:0] HOST_OFS = 9'd0;
  logic [2:0] A;
  logic [7:0] D;
  logic       LATCH, BUSY, DONE, OVERRUN;

  scroll_latch_writer #(
    .LAYERS(LAYERS), .SETUP_CYCLES(SETUP_CYCLES),
    .STROBE_CYCLES(STROBE_CYCLES), .STEP(STEP)
  ) dut (
    .CLK_6M(CLK_6M), .RST_N(RST_N), .VBLANK(VBLANK), .EN(EN),
    .AUTO_INC(AUTO_INC), .HOST_WE(HOST_WE), .HOST_SEL(HOST_SEL),
    .HOST_OFS(HOST_OFS), .A(A), .D(D), .LATCH(LATCH), .BUSY(BUSY),
    .DONE(DONE), .OVERRUN(OVERRUN)
  );

  always #5 CLK_6M = ~CLK_6M;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- frame-level reference model ----------------
  // A frame is described by the edge at which LOAD is entered (seq_start);
  // everything the outputs do afterwards is arithmetic on the offset from it.
  logic [8:0] m_ofs [4];
  logic [8:0] m_snap [4];
  bit         m_dirty, m_ovr, vb_prev;
  int         edge_n, seq_start;
  int         pend[$];

  always @(posedge CLK_6M or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < 4; i++) begin
        m_ofs[i]  = 9'd0;
        m_snap[i] = 9'd0;
      end
      m_dirty   = 1'b0;
      m_ovr     = 1'b0;
      vb_prev   = 1'b0;
      edge_n    = 0;
      seq_start = -100000;
      pend.delete();
    end else begin
      bit host_ok;
      edge_n++;
      host_ok = HOST_WE && (int'(HOST_SEL) < LAYERS);
      // Frame decision two edges after the synchronizer sees the rise.
      if (pend.size() > 0 && pend[0] == edge_n) begin
        void'(pend.pop_front());
        if (edge_n > seq_start && edge_n <= seq_start + SEQ_LEN) m_ovr = 1'b1;
        else if (EN || m_dirty || AUTO_INC) seq_start = edge_n;
      end
      if (edge_n == seq_start + 1) begin
        for (int i = 0; i < LAYERS; i++) begin
          if (host_ok && int'(HOST_SEL) == i) m_ofs[i] = HOST_OFS;
          else if (AUTO_INC) m_ofs[i] = m_ofs[i] + 9'(STEP);
          m_snap[i] = m_ofs[i];
        end
        m_dirty = host_ok;
      end else if (host_ok) begin
        m_ofs[HOST_SEL] = HOST_OFS;
        m_dirty = 1'b1;
      end
      if (VBLANK && !vb_prev) pend.push_back(edge_n + 2);
      vb_prev = VBLANK;
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge CLK_6M) begin
    if (RST_N) begin
      int o, j, p;
      logic [2:0] ea;
      logic [7:0] ed;
      logic [8:0] v;
      logic el, eb, edn;
      o = edge_n - seq_start;
      ea = 3'd0; ed = 8'd0; el = 1'b0; eb = 1'b0; edn = 1'b0;
      if (o >= 0 && o <= SEQ_LEN - 1) begin
        eb = 1'b1;
        if (o == SEQ_LEN - 1) edn = 1'b1;
        else if (o >= 1) begin
          j  = (o - 1) / WR_LEN;
          p  = (o - 1) % WR_LEN;
          ea = {2'(j / 2), 1'(j % 2)};
          v  = m_snap[j / 2];
          ed = (j % 2 == 1) ? {7'b0, v[8]} : v[7:0];
          el = (p >= SETUP_CYCLES) && (p < SETUP_CYCLES + STROBE_CYCLES);
        end
      end
      check_eq("A", 32'(A), 32'(ea));
      check_eq("D", 32'(D), 32'(ed));
      check_eq("LATCH", 32'(LATCH), 32'(el));
      check_eq("BUSY", 32'(BUSY), 32'(eb));
      check_eq("DONE", 32'(DONE), 32'(edn));
      check_eq("OVERRUN", 32'(OVERRUN), 32'(m_ovr));
    end
  end

  // Transaction log: one line per latched write.
  logic [10:0] obs[$];
  logic        latch_prev = 1'b0;
  always @(negedge CLK_6M) begin
    if (LATCH && !latch_prev) begin
      obs.push_back({A, D});
      $display("write A=%0d D=0x%02h t=%0t", A, D, $time);
    end
    latch_prev = LATCH;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge CLK_6M);
  endtask

  task automatic host_write(input logic [1:0] sel, input logic [8:0] ofs);
    @(negedge CLK_6M);
    HOST_WE = 1'b1; HOST_SEL = sel; HOST_OFS = ofs;
    @(negedge CLK_6M);
    HOST_WE = 1'b0;
  endtask

  task automatic vblank_pulse();
    @(negedge CLK_6M);
    VBLANK = 1'b1;
    cycles(3);
    VBLANK = 1'b0;
  endtask

  task automatic wait_latch();
    bit seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      @(negedge CLK_6M);
      if (LATCH) seen = 1'b1;
    end
    check_eq("latch_timeout", 32'(seen), 32'd1);
  endtask

  task automatic check_obs(input string tag, input int idx, input logic [10:0] exp);
    logic [10:0] got;
    got = (idx < obs.size()) ? obs[idx] : 11'h7FF;
    check_eq(tag, 32'(got), 32'(exp));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    cycles(3);
    check_eq("rst_A", 32'(A), 32'd0);
    check_eq("rst_LATCH", 32'(LATCH), 32'd0);
    check_eq("rst_BUSY", 32'(BUSY), 32'd0);
    check_eq("rst_OVERRUN", 32'(OVERRUN), 32'd0);
    RST_N = 1'b1;
    cycles(2);

    // Dirty-only frame, then a clean frame that must stay silent.
    host_write(2'd0, 9'h1A5);
    host_write(2'd1, 9'h003);
    obs.delete();
    vblank_pulse();
    cycles(25);
    check_eq("p1_count", 32'(obs.size()), 32'd4);
    check_obs("p1_w0", 0, {3'd0, 8'hA5});
    check_obs("p1_w1", 1, {3'd1, 8'h01});
    check_obs("p1_w2", 2, {3'd2, 8'h03});
    check_obs("p1_w3", 3, {3'd3, 8'h00});
    obs.delete();
    vblank_pulse();
    cycles(25);
    check_eq("p1_clean_count", 32'(obs.size()), 32'd0);

    // Auto-increment wrap 0x1FF -> 0x000 -> 0x001.
    @(negedge CLK_6M);
    AUTO_INC = 1'b1; EN = 1'b1;
    host_write(2'd0, 9'h1FF);
    obs.delete();
    vblank_pulse();
    cycles(25);
    check_obs("p2_f1_lo", 0, {3'd0, 8'h00});
    check_obs("p2_f1_hi", 1, {3'd1, 8'h00});
    obs.delete();
    vblank_pulse();
    cycles(25);
    check_obs("p2_f2_lo", 0, {3'd0, 8'h01});
    AUTO_INC = 1'b0;

    // Host write during the first strobe affects only the next frame.
    obs.delete();
    vblank_pulse();
    wait_latch();
    HOST_WE = 1'b1; HOST_SEL = 2'd0; HOST_OFS = 9'h055;
    @(negedge CLK_6M);
    HOST_WE = 1'b0;
    cycles(25);
    check_obs("p3_old_lo", 0, {3'd0, 8'h01});
    obs.delete();
    vblank_pulse();
    cycles(25);
    check_obs("p3_new_lo", 0, {3'd0, 8'h55});
    check_obs("p3_new_hi", 1, {3'd1, 8'h00});

    // Second rise while busy: sticky overrun, no extra sequence.
    obs.delete();
    @(negedge CLK_6M);
    VBLANK = 1'b1; cycles(2); VBLANK = 1'b0; cycles(2); VBLANK = 1'b1; cycles(2); VBLANK = 1'b0;
    cycles(30);
    check_eq("p4_overrun", 32'(OVERRUN), 32'd1);
    check_eq("p4_count", 32'(obs.size()), 32'd4);
    cycles(10);
    check_eq("p4_overrun_sticky", 32'(OVERRUN), 32'd1);

    // Asynchronous reset in the middle of a strobe.
    vblank_pulse();
    wait_latch();
    #2 RST_N = 1'b0;
    #1;
    check_eq("p5_LATCH", 32'(LATCH), 32'd0);
    check_eq("p5_BUSY", 32'(BUSY), 32'd0);
    check_eq("p5_A", 32'(A), 32'd0);
    check_eq("p5_D", 32'(D), 32'd0);
    check_eq("p5_OVERRUN", 32'(OVERRUN), 32'd0);
    cycles(3);
    RST_N = 1'b1;
    cycles(2);
    obs.delete();
    EN = 1'b1;
    vblank_pulse();
    cycles(25);
    check_eq("p5_count", 32'(obs.size()), 32'd4);
    for (int i = 0; i < 4; i++) check_obs("p5_zero", i, {3'(i), 8'h00});

    // Writes to layers that do not exist are ignored and do not mark dirty.
    EN = 1'b0;
    host_write(2'd2, 9'h1AB);
    host_write(2'd3, 9'h0CD);
    obs.delete();
    vblank_pulse();
    cycles(25);
    check_eq("p6_count", 32'(obs.size()), 32'd0);

    // Randomized run, checked by the per-cycle model.
    for (int c = 0; c < 4000; c++) begin
      @(negedge CLK_6M);
      if ($urandom_range(0, 11) == 0) VBLANK = ~VBLANK;
      HOST_WE  = ($urandom_range(0, 7) == 0);
      HOST_SEL = 2'($urandom_range(0, 3));
      HOST_OFS = 9'($urandom);
      if (c % 250 == 0) begin
        EN       = 1'($urandom);
        AUTO_INC = 1'($urandom);
      end
    end
    HOST_WE = 1'b0;
    VBLANK  = 1'b0;
    cycles(30);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
